// File: rtl/two_level_pkg.sv
// Shared encodings, default truth tables and output bundle for the two_level LUT stage.
package two_level_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'd0,
    OP_AND = 2'd1,
    OP_XOR = 2'd2,
    OP_NOR = 2'd3
  } f_op_e;

  localparam logic [15:0] T1_AND_AB = 16'hF000;
  localparam logic [15:0] T2_AND_CD = 16'h8888;

  typedef struct packed {
    logic t1;
    logic t2;
    logic f;
  } tl_out_t;

  // Second-level combine of the two first-level terms.
  function automatic logic f_op_eval(input logic [1:0] op, input logic x, input logic y);
    logic r;
    r = 1'b0;
    case (op)
      OP_OR:   r = x | y;
      OP_AND:  r = x & y;
      OP_XOR:  r = x ^ y;
      OP_NOR:  r = ~(x | y);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/two_level_lut4.sv
// 4-input lookup table; INIT bit idx is the output for that input combination.
module lut4 #(
  parameter logic [15:0] INIT = 16'h0000
) (
  input  logic [3:0] idx,
  output logic       o
);
  assign o = INIT[idx];
endmodule

// File: rtl/two_level.sv
// Two-level LUT stage: two 4-input LUTs combined by a 2-input operator, optionally registered.
module two_level
  import two_level_pkg::*;
#(
  parameter logic [15:0] T1_INIT = T1_AND_AB,
  parameter logic [15:0] T2_INIT = T2_AND_CD,
  parameter logic [1:0]  F_OP    = 2'd0,
  parameter int unsigned REG_OUT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic t1,
  output logic t2,
  output logic f
);

  logic [3:0] idx;
  logic       t1_n;
  logic       t2_n;
  tl_out_t    nxt;

  assign idx = {a, b, c, d};

  lut4 #(.INIT(T1_INIT)) u_lut_t1 (.idx(idx), .o(t1_n));
  lut4 #(.INIT(T2_INIT)) u_lut_t2 (.idx(idx), .o(t2_n));

  // f comes from the same-cycle terms so all three outputs stay coherent after the register.
  always_comb begin
    nxt    = '0;
    nxt.t1 = t1_n;
    nxt.t2 = t2_n;
    nxt.f  = f_op_eval(F_OP, t1_n, t2_n);
  end

  generate
    if (REG_OUT != 0) begin : g_reg
      tl_out_t q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= nxt;
      end

      assign t1 = q.t1;
      assign t2 = q.t2;
      assign f  = q.f;
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;

      assign t1 = nxt.t1;
      assign t2 = nxt.t2;
      assign f  = nxt.f;
    end
  endgenerate

endmodule

// File: tb/tb_two_level.sv
// Directed bench for two_level: four registered operator variants plus a combinational parity build.
module tb_two_level;
  import two_level_pkg::*;

  typedef struct {
    logic t1;
    logic t2;
    logic f_or;
    logic f_and;
    logic f_xor;
    logic f_nor;
  } exp_t;

  logic clk = 1'b0;
  logic clk_run = 1'b1;
  logic rst = 1'b1;
  logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;

  // index 0: OR (default), 1: AND, 2: XOR, 3: NOR, 4: combinational parity
  logic [4:0] t1_v, t2_v, f_v;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  always #5 if (clk_run) clk = ~clk;

  two_level dut_or (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
                    .t1(t1_v[0]), .t2(t2_v[0]), .f(f_v[0]));
  two_level #(.F_OP(2'd1)) dut_and (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
                    .t1(t1_v[1]), .t2(t2_v[1]), .f(f_v[1]));
  two_level #(.F_OP(2'd2)) dut_xor (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
                    .t1(t1_v[2]), .t2(t2_v[2]), .f(f_v[2]));
  two_level #(.F_OP(2'd3)) dut_nor (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
                    .t1(t1_v[3]), .t2(t2_v[3]), .f(f_v[3]));
  two_level #(.T1_INIT(16'h6996), .REG_OUT(0)) dut_comb (.clk(clk), .rst(rst),
                    .a(a), .b(b), .c(c), .d(d),
                    .t1(t1_v[4]), .t2(t2_v[4]), .f(f_v[4]));

  function automatic exp_t model(input logic [3:0] v);
    exp_t m;
    logic x, y;
    x = v[3] & v[2];
    y = v[1] & v[0];
    m.t1    = x;
    m.t2    = y;
    m.f_or  = x | y;
    m.f_and = x & y;
    m.f_xor = x ^ y;
    m.f_nor = ~(x | y);
    return m;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_exp(input string tag, input exp_t e);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s.t1[%0d]", tag, i), t1_v[i], e.t1);
      chk($sformatf("%s.t2[%0d]", tag, i), t2_v[i], e.t2);
    end
    chk({tag, ".f_or"},  f_v[0], e.f_or);
    chk({tag, ".f_and"}, f_v[1], e.f_and);
    chk({tag, ".f_xor"}, f_v[2], e.f_xor);
    chk({tag, ".f_nor"}, f_v[3], e.f_nor);
  endtask

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s.t1[%0d]", tag, i), t1_v[i], 1'b0);
      chk($sformatf("%s.t2[%0d]", tag, i), t2_v[i], 1'b0);
      chk($sformatf("%s.f[%0d]",  tag, i), f_v[i],  1'b0);
    end
  endtask

  // Outputs captured on the posedge between two negedges belong to the oldest queued vector.
  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk_exp("sb", e);
  endtask

  task automatic drive(input logic [3:0] v);
    @(negedge clk);
    check_out();
    {a, b, c, d} = v;
    sb.push_back(model(v));
  endtask

  initial begin
    logic [3:0] vec;

    // Reset state, including NOR where the unregistered value would be 1.
    #2;
    chk_zero("reset_init");
    @(negedge clk);
    rst = 1'b0;

    // 1111 captured, then reset asserted mid-cycle clears without a clock edge.
    drive(4'b1111);
    @(negedge clk);
    check_out();
    #2 rst = 1'b1;
    #1 chk_zero("reset_async");
    @(negedge clk);
    rst = 1'b0;
    #1 chk_zero("reset_release_hold");
    @(posedge clk);
    #1 chk_exp("reset_first_capture", model(4'b1111));

    // Low vectors, then the named patterns, then all 16 back-to-back.
    drive(4'b0000);
    drive(4'b0001);
    drive(4'b0010);
    drive(4'b0011);
    drive(4'b1100);
    drive(4'b1111);
    drive(4'b1010);
    for (int i = 0; i < 16; i++) begin
      vec = 4'(i);
      drive(vec);
    end
    drive(4'b1111);
    drive(4'b1100);
    drive(4'b0000);
    @(negedge clk);
    check_out();
    chk("sb_drained", sb.size() == 0, 1'b1);

    // NOR variant holds 0 under reset with inputs at 0000.
    rst = 1'b1;
    #1 chk("nor_in_reset", f_v[3], 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Combinational parity build with the clock stopped low.
    @(negedge clk);
    clk_run = 1'b0;
    {a, b, c, d} = 4'b0111;
    #1;
    chk("comb_0111.t1", t1_v[4], 1'b1);
    chk("comb_0111.t2", t2_v[4], 1'b1);
    chk("comb_0111.f",  f_v[4],  1'b1);
    {a, b, c, d} = 4'b0001;
    #1;
    chk("comb_0001.t1", t1_v[4], 1'b1);
    chk("comb_0001.t2", t2_v[4], 1'b0);
    chk("comb_0001.f",  f_v[4],  1'b1);
    {a, b, c, d} = 4'b0110;
    #1;
    chk("comb_0110.t1", t1_v[4], 1'b0);
    chk("comb_0110.t2", t2_v[4], 1'b0);
    chk("comb_0110.f",  f_v[4],  1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
